// File: rtl/alu_arbiter_if.sv
// Bundles the two requester ports, the shared-ALU port and the response port
// of alu_arbiter; slave is the arbiter side, master is the surrounding system.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_rs1;
  logic [WIDTH-1:0] req0_rs2;
  logic [33:0]      req0_ctrl;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_rs1;
  logic [WIDTH-1:0] req1_rs2;
  logic [33:0]      req1_ctrl;

  logic [WIDTH-1:0] alu_rs1;
  logic [WIDTH-1:0] alu_rs2;
  logic [6:0]       alu_opcode;
  logic [6:0]       alu_funct7;
  logic [2:0]       alu_funct3;
  logic [11:0]      alu_imm;
  logic [4:0]       alu_shamt;
  logic [WIDTH-1:0] alu_rd;
  logic [WIDTH-1:0] alu_mem_addr;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_rd;
  logic [WIDTH-1:0] rsp_mem_addr;

  modport slave (
    input  req0_valid, req0_rs1, req0_rs2, req0_ctrl,
    output req0_ready,
    input  req1_valid, req1_rs1, req1_rs2, req1_ctrl,
    output req1_ready,
    output alu_rs1, alu_rs2, alu_opcode, alu_funct7, alu_funct3, alu_imm, alu_shamt,
    input  alu_rd, alu_mem_addr,
    output rsp_valid, rsp_id, rsp_rd, rsp_mem_addr,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_rs1, req0_rs2, req0_ctrl,
    input  req0_ready,
    output req1_valid, req1_rs1, req1_rs2, req1_ctrl,
    input  req1_ready,
    input  alu_rs1, alu_rs2, alu_opcode, alu_funct7, alu_funct3, alu_imm, alu_shamt,
    output alu_rd, alu_mem_addr,
    input  rsp_valid, rsp_id, rsp_rd, rsp_mem_addr,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU:
// accept one operation, let the ALU settle for a cycle, hold the result until taken.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic [4:0]  shamt;
  } ctrl_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             owner;

  logic [WIDTH-1:0] op_rs1;
  logic [WIDTH-1:0] op_rs2;
  ctrl_t            op_ctrl;

  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_rd_q;
  logic [WIDTH-1:0] rsp_mem_addr_q;

  logic             gnt_valid;
  logic             gnt_id;
  logic [WIDTH-1:0] sel_rs1;
  logic [WIDTH-1:0] sel_rs2;
  ctrl_t            sel_ctrl;

  // Grant is only offered in IDLE and never while reset is held, so a
  // requester cannot see ready during reset even though the state reads IDLE.
  // NOTE: every output of an always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state == IDLE && rst) begin
      unique case ({bus.req1_valid, bus.req0_valid})
        2'b01: begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b0;
        end
        2'b10: begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b1;
        end
        2'b11: begin
          gnt_valid = 1'b1;
          gnt_id    = ~last_grant;
        end
        default: begin
          gnt_valid = 1'b0;
          gnt_id    = 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready = gnt_valid && !gnt_id;
  assign bus.req1_ready = gnt_valid && gnt_id;

  assign sel_rs1  = gnt_id ? bus.req1_rs1 : bus.req0_rs1;
  assign sel_rs2  = gnt_id ? bus.req1_rs2 : bus.req0_rs2;
  assign sel_ctrl = gnt_id ? ctrl_t'(bus.req1_ctrl) : ctrl_t'(bus.req0_ctrl);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand register: loaded only on a handshake, so the ALU inputs stay
  // quiet between operations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_rs1     <= '0;
      op_rs2     <= '0;
      op_ctrl    <= '0;
    end else if (gnt_valid) begin
      last_grant <= gnt_id;
      owner      <= gnt_id;
      op_rs1     <= sel_rs1;
      op_rs2     <= sel_rs2;
      op_ctrl    <= sel_ctrl;
    end
  end

  // Result capture happens only in EXEC; RESP holds these until the consumer
  // takes them, which keeps rsp_* stable under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_id_q       <= 1'b0;
      rsp_rd_q       <= '0;
      rsp_mem_addr_q <= '0;
    end else if (state == EXEC) begin
      rsp_id_q       <= owner;
      rsp_rd_q       <= bus.alu_rd;
      rsp_mem_addr_q <= bus.alu_mem_addr;
    end
  end

  // Opcode is forced to zero in IDLE so the ALU sees a no-op between jobs.
  assign bus.alu_rs1    = op_rs1;
  assign bus.alu_rs2    = op_rs2;
  assign bus.alu_opcode = (state == IDLE) ? 7'b0000000 : op_ctrl.opcode;
  assign bus.alu_funct7 = op_ctrl.funct7;
  assign bus.alu_funct3 = op_ctrl.funct3;
  assign bus.alu_imm    = op_ctrl.imm;
  assign bus.alu_shamt  = op_ctrl.shamt;

  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_rd       = rsp_rd_q;
  assign bus.rsp_mem_addr = rsp_mem_addr_q;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter with a behavioural ALU and a
// transaction-level arbiter model; all DUT outputs are checked every cycle.
module tb_alu_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic [33:0]  ctrl;
  } op_t;

  typedef struct {
    int           id;
    logic [W-1:0] rd;
    logic [W-1:0] addr;
  } rsp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  op_t  pend [2];
  bit   have [2];
  bit   rsp_rdy  = 1'b1;
  bit   rst_drv  = 1'b0;

  // model: phase 0 = free to accept, 1 = result settling, 2 = result offered
  int   phase    = 0;
  int   last     = 1;
  op_t  exp_op;
  rsp_t exp_rsp;

  rsp_t got_q [$];
  int   grant_q [$];
  int   gcount [2];
  int   rcount [2];
  int   grant_cyc  = 0;
  bit   prev_valid = 1'b0;

  function automatic logic [33:0] mk_ctrl(input logic [6:0] op, input logic [6:0] f7,
                                          input logic [2:0] f3, input logic [11:0] imm,
                                          input logic [4:0] sh);
    return {op, f7, f3, imm, sh};
  endfunction

  function automatic logic [W-1:0] sext_imm(input logic [33:0] c);
    logic [11:0] imm;
    imm = c[16:5];
    return {{(W-12){imm[11]}}, imm};
  endfunction

  function automatic logic [W-1:0] ref_rd(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [33:0] c);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] sh;
    op = c[33:27];
    f7 = c[26:20];
    f3 = c[19:17];
    sh = c[4:0];
    if (op == 7'b0110011) begin
      case (f3)
        3'd0:    return (f7 == 7'h20) ? a - b : a + b;
        3'd1:    return a << b[4:0];
        3'd4:    return a ^ b;
        3'd6:    return a | b;
        3'd7:    return a & b;
        default: return a + b;
      endcase
    end else if (op == 7'b0010011 && f3 == 3'd1) begin
      return a << sh;
    end
    return a + sext_imm(c);
  endfunction

  function automatic logic [W-1:0] ref_addr(input logic [W-1:0] a, input logic [33:0] c);
    return a + sext_imm(c);
  endfunction

  // Behavioural shared ALU hanging off the DUT's ALU port.
  assign bus.alu_rd = ref_rd(bus.alu_rs1, bus.alu_rs2,
                             {bus.alu_opcode, bus.alu_funct7, bus.alu_funct3,
                              bus.alu_imm, bus.alu_shamt});
  assign bus.alu_mem_addr = ref_addr(bus.alu_rs1,
                                     {bus.alu_opcode, bus.alu_funct7, bus.alu_funct3,
                                      bus.alu_imm, bus.alu_shamt});

  function automatic op_t rand_op();
    op_t o;
    logic [11:0] imm;
    imm   = 12'($urandom);
    o.rs1 = $urandom;
    o.rs2 = $urandom;
    case ($urandom_range(0, 8))
      0:       o.ctrl = mk_ctrl(7'b0110011, 7'h00, 3'd0, 12'h0, 5'd0);
      1:       o.ctrl = mk_ctrl(7'b0110011, 7'h20, 3'd0, 12'h0, 5'd0);
      2:       o.ctrl = mk_ctrl(7'b0110011, 7'h00, 3'd4, 12'h0, 5'd0);
      3:       o.ctrl = mk_ctrl(7'b0110011, 7'h00, 3'd6, 12'h0, 5'd0);
      4:       o.ctrl = mk_ctrl(7'b0110011, 7'h00, 3'd7, 12'h0, 5'd0);
      5:       o.ctrl = mk_ctrl(7'b0010011, 7'h00, 3'd0, imm, 5'd0);
      6:       o.ctrl = mk_ctrl(7'b0000011, 7'h00, 3'd2, imm, 5'd0);
      7:       o.ctrl = mk_ctrl(7'b0100011, 7'h00, 3'd2, imm, 5'd0);
      default: o.ctrl = mk_ctrl(7'b0010011, 7'h00, 3'd1, 12'h0, 5'($urandom));
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare shortly after, then
  // advance the model to what the next rising edge should do.
  task automatic step();
    int g;
    @(negedge clk);
    rst = rst_drv;
    if (!rst_drv) begin
      phase = 0;
      last  = 1;
    end
    bus.req0_valid = have[0];
    bus.req0_rs1   = pend[0].rs1;
    bus.req0_rs2   = pend[0].rs2;
    bus.req0_ctrl  = pend[0].ctrl;
    bus.req1_valid = have[1];
    bus.req1_rs1   = pend[1].rs1;
    bus.req1_rs2   = pend[1].rs2;
    bus.req1_ctrl  = pend[1].ctrl;
    bus.rsp_ready  = rsp_rdy;
    #1;
    cyc++;

    g = -1;
    if (phase == 0 && rst_drv) begin
      if (have[0] && have[1]) g = (last == 1) ? 0 : 1;
      else if (have[0])       g = 0;
      else if (have[1])       g = 1;
    end

    check("req0_ready", bus.req0_ready, g == 0);
    check("req1_ready", bus.req1_ready, g == 1);
    check("busy", busy, phase != 0);
    check("rsp_valid", bus.rsp_valid, phase == 2);
    if (phase == 0) check("alu_opcode_idle", bus.alu_opcode, 7'h00);
    if (phase == 1) begin
      check("alu_rs1", bus.alu_rs1, exp_op.rs1);
      check("alu_rs2", bus.alu_rs2, exp_op.rs2);
      check("alu_ctrl", {bus.alu_opcode, bus.alu_funct7, bus.alu_funct3, bus.alu_imm,
                         bus.alu_shamt}, exp_op.ctrl);
    end
    if (phase == 2) begin
      check("rsp_id", bus.rsp_id, exp_rsp.id);
      check("rsp_rd", bus.rsp_rd, exp_rsp.rd);
      check("rsp_mem_addr", bus.rsp_mem_addr, exp_rsp.addr);
    end
    if (!rst_drv) begin
      check("rst_rsp_rd", bus.rsp_rd, 0);
      check("rst_rsp_mem_addr", bus.rsp_mem_addr, 0);
      check("rst_rsp_id", bus.rsp_id, 0);
      check("rst_alu_rs1", bus.alu_rs1, 0);
    end
    if (bus.rsp_valid && !prev_valid) check("latency", cyc - grant_cyc, 2);
    prev_valid = bus.rsp_valid;

    // requesters and consumer react to what the DUT actually shows
    for (int i = 0; i < 2; i++) begin
      if (have[i] && (i == 0 ? bus.req0_ready : bus.req1_ready)) begin
        have[i]   = 1'b0;
        grant_cyc = cyc;
        grant_q.push_back(i);
        gcount[i]++;
      end
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      got_q.push_back('{int'(bus.rsp_id), bus.rsp_rd, bus.rsp_mem_addr});
      rcount[int'(bus.rsp_id)]++;
    end

    if (rst_drv) begin
      case (phase)
        0: if (g >= 0) begin
             exp_op       = pend[g];
             exp_rsp.id   = g;
             exp_rsp.rd   = ref_rd(pend[g].rs1, pend[g].rs2, pend[g].ctrl);
             exp_rsp.addr = ref_addr(pend[g].rs1, pend[g].ctrl);
             last         = g;
             phase        = 1;
           end
        1: phase = 2;
        default: if (rsp_rdy) phase = 0;
      endcase
    end
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin
      step();
      c++;
    end
    if (got_q.size() < n) check({tag, "_timeout"}, got_q.size(), n);
  endtask

  initial begin
    int n0;
    int n1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_rs1 = '0; bus.req0_rs2 = '0; bus.req0_ctrl = '0;
    bus.req1_rs1 = '0; bus.req1_rs2 = '0; bus.req1_ctrl = '0;
    bus.rsp_ready = 1'b0;
    have[0] = 1'b0;
    have[1] = 1'b0;

    // reset state
    rst_drv = 1'b0;
    repeat (3) step();
    rst_drv = 1'b1;

    // single ADD from req0
    pend[0] = '{32'd5, 32'd3, mk_ctrl(7'b0110011, 7'h00, 3'd0, 12'h0, 5'd0)};
    have[0] = 1'b1;
    rsp_rdy = 1'b1;
    got_q.delete();
    run_until(1, 20, "add");
    if (got_q.size() >= 1) begin
      check("add_id", got_q[0].id, 0);
      check("add_rd", got_q[0].rd, 8);
    end

    // tie out of reset: req0 first, then req1
    rst_drv = 1'b0;
    step();
    pend[0] = '{32'd1, 32'd1, mk_ctrl(7'b0110011, 7'h00, 3'd0, 12'h0, 5'd0)};
    pend[1] = '{32'd10, 32'd4, mk_ctrl(7'b0110011, 7'h20, 3'd0, 12'h0, 5'd0)};
    have[0] = 1'b1;
    have[1] = 1'b1;
    step();
    rst_drv = 1'b1;
    got_q.delete();
    run_until(2, 30, "tie");
    if (got_q.size() >= 2) begin
      check("tie_first_id", got_q[0].id, 0);
      check("tie_first_rd", got_q[0].rd, 2);
      check("tie_second_id", got_q[1].id, 1);
      check("tie_second_rd", got_q[1].rd, 6);
    end

    // six back-to-back ops with both requesters always valid
    grant_q.delete();
    got_q.delete();
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 80 && got_q.size() < 6; c++) begin
      if (!have[0] && n0 < 3) begin pend[0] = rand_op(); have[0] = 1'b1; n0++; end
      if (!have[1] && n1 < 3) begin pend[1] = rand_op(); have[1] = 1'b1; n1++; end
      step();
    end
    check("rr_count", got_q.size(), 6);
    for (int i = 0; i < 6 && i < grant_q.size(); i++) check("rr_grant", grant_q[i], i % 2);
    for (int i = 0; i < 6 && i < got_q.size(); i++) check("rr_rsp_id", got_q[i].id, i % 2);

    // backpressure: response held for 5 cycles while req1 waits
    pend[0] = rand_op();
    pend[1] = rand_op();
    have[0] = 1'b1;
    have[1] = 1'b1;
    rsp_rdy = 1'b0;
    got_q.delete();
    for (int c = 0; c < 10 && phase != 2; c++) step();
    check("bp_reached_resp", phase, 2);
    repeat (5) step();
    check("bp_req1_waiting", have[1], 1);
    check("bp_nothing_taken", got_q.size(), 0);
    rsp_rdy = 1'b1;
    run_until(2, 20, "bp");
    if (got_q.size() >= 2) begin
      check("bp_first_id", got_q[0].id, 0);
      check("bp_second_id", got_q[1].id, 1);
    end

    // load address generation
    pend[0] = '{32'h100, 32'h0, mk_ctrl(7'b0000011, 7'h00, 3'd2, 12'h010, 5'd0)};
    have[0] = 1'b1;
    got_q.delete();
    run_until(1, 20, "load");
    if (got_q.size() >= 1) check("load_addr", got_q[0].addr, 32'h110);

    // reset during EXEC aborts the op; the following tie goes to req0
    pend[1] = rand_op();
    have[1] = 1'b1;
    got_q.delete();
    for (int c = 0; c < 10 && phase != 1; c++) step();
    check("abort_in_exec", phase, 1);
    rst_drv = 1'b0;
    repeat (2) step();
    check("abort_no_rsp", got_q.size(), 0);
    pend[0] = '{32'd7, 32'd9, mk_ctrl(7'b0110011, 7'h00, 3'd0, 12'h0, 5'd0)};
    pend[1] = '{32'd20, 32'd5, mk_ctrl(7'b0110011, 7'h20, 3'd0, 12'h0, 5'd0)};
    have[0] = 1'b1;
    have[1] = 1'b1;
    rst_drv = 1'b1;
    run_until(2, 30, "abort");
    check("abort_total_rsp", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("abort_first_id", got_q[0].id, 0);
      check("abort_first_rd", got_q[0].rd, 16);
      check("abort_second_rd", got_q[1].rd, 15);
    end

    // random traffic with random backpressure; nothing may be lost
    gcount[0] = 0; gcount[1] = 0;
    rcount[0] = 0; rcount[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!have[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = rand_op();
          have[i] = 1'b1;
        end
      end
      rsp_rdy = ($urandom_range(0, 9) < 7);
      step();
    end
    rsp_rdy = 1'b1;
    for (int c = 0; c < 40 && (have[0] || have[1] || phase != 0); c++) step();
    check("drain_idle", phase, 0);
    check("rand_lost0", rcount[0], gcount[0]);
    check("rand_lost1", rcount[1], gcount[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
